// File: rtl/pc_unit.sv
// pc_unit: fetch program-counter unit at the head of the IF stage.
// It provides sequential increment, an EX branch/jump redirect, a trap redirect,
// a one-cycle boot state, a flush pulse, misaligned-target handling and a fetch counter.
// Optional feature macro: PC_MISALIGN_TRAP_EN.
//   Defined:   a misaligned redirect is rejected. The unit pulses o_misaligned and
//              parks in HALT until a trap arrives.
//   Undefined: a misaligned redirect is accepted with its alignment bits cleared.
//              o_misaligned and o_misaligned_addr are tied low.
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int              IALIGN       = 32,
    parameter int              CNT_W        = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_pc_en,
    input  logic             i_redirect_valid,
    input  logic [XLEN-1:0]  i_redirect_pc,
    input  logic             i_trap_valid,
    output logic [XLEN-1:0]  o_pc,
    output logic [XLEN-1:0]  o_pc_plus_step,
    output logic             o_fetch_valid,
    output logic             o_flush,
    output logic             o_misaligned,
    output logic [XLEN-1:0]  o_misaligned_addr,
    output logic [CNT_W-1:0] o_fetch_count
);

    // Byte step between sequential instructions, and the number of low address
    // bits that must be zero for a legal target.
    localparam int              ALIGN_BITS = (IALIGN == 16) ? 1 : 2;
    localparam logic [XLEN-1:0] STEP       = XLEN'(IALIGN / 8);

`ifdef PC_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1
    } state_t;
`endif

    state_t           r_state;
    logic [XLEN-1:0]  r_pc;
    logic             r_fetch_valid;
    logic             r_flush;
    logic [CNT_W-1:0] r_fetch_count;

    // Mask that selects the alignment bits.
    logic [XLEN-1:0]  w_align_mask;
    logic [XLEN-1:0]  w_trap_target;
    logic [XLEN-1:0]  w_pc_plus_step;
    logic             w_redirect_aligned;

    genvar gi;
    generate
        for (gi = 0; gi < XLEN; gi++) begin : g_align_mask
            assign w_align_mask[gi] = (gi < ALIGN_BITS);
        end
    endgenerate

    assign w_trap_target      = TRAP_VECTOR & ~w_align_mask;
    assign w_pc_plus_step     = r_pc + STEP;
    assign w_redirect_aligned = ((i_redirect_pc & w_align_mask) == '0);

`ifdef PC_MISALIGN_TRAP_EN
    logic            r_misaligned;
    logic [XLEN-1:0] r_misaligned_addr;
`else
    // The target with its alignment bits cleared. This is used only when a
    // misaligned redirect is accepted instead of being rejected.
    logic [XLEN-1:0] w_redirect_masked;
    assign w_redirect_masked = i_redirect_pc & ~w_align_mask;
`endif

    // Single state machine. All outputs are registered and move with the state.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state           <= S_BOOT;
            r_pc              <= RESET_VECTOR;
            r_fetch_valid     <= 1'b0;
            r_flush           <= 1'b0;
            r_fetch_count     <= '0;
`ifdef PC_MISALIGN_TRAP_EN
            r_misaligned      <= 1'b0;
            r_misaligned_addr <= '0;
`endif
        end else begin
            // Both pulses are low unless this edge raises them.
            r_flush      <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
            r_misaligned <= 1'b0;
`endif
            case (r_state)
                S_BOOT: begin
                    // The PC stays at RESET_VECTOR, so the first real fetch is the reset vector.
                    r_state       <= S_RUN;
                    r_fetch_valid <= 1'b1;
                end
                S_RUN: begin
                    if (i_trap_valid) begin
                        // A trap wins over a simultaneous redirect, and the redirect is lost.
                        r_pc          <= w_trap_target;
                        r_flush       <= 1'b1;
                        r_fetch_count <= r_fetch_count + CNT_W'(1);
                    end else if (i_redirect_valid) begin
                        if (w_redirect_aligned) begin
                            r_pc          <= i_redirect_pc;
                            r_flush       <= 1'b1;
                            r_fetch_count <= r_fetch_count + CNT_W'(1);
                        end else begin
`ifdef PC_MISALIGN_TRAP_EN
                            // Reject the target and hold the PC until software traps out.
                            r_misaligned      <= 1'b1;
                            r_misaligned_addr <= i_redirect_pc;
                            r_state           <= S_HALT;
                            r_fetch_valid     <= 1'b0;
`else
                            r_pc          <= w_redirect_masked;
                            r_flush       <= 1'b1;
                            r_fetch_count <= r_fetch_count + CNT_W'(1);
`endif
                        end
                    end else if (i_pc_en) begin
                        r_pc          <= w_pc_plus_step;
                        r_fetch_count <= r_fetch_count + CNT_W'(1);
                    end
                end
`ifdef PC_MISALIGN_TRAP_EN
                S_HALT: begin
                    // Only a trap leaves HALT. No fetch is live here, so the counter holds.
                    if (i_trap_valid) begin
                        r_pc          <= w_trap_target;
                        r_flush       <= 1'b1;
                        r_state       <= S_RUN;
                        r_fetch_valid <= 1'b1;
                    end
                end
`endif
                default: begin
                    r_state       <= S_BOOT;
                    r_pc          <= RESET_VECTOR;
                    r_fetch_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_pc           = r_pc;
    assign o_pc_plus_step = w_pc_plus_step;
    assign o_fetch_valid  = r_fetch_valid;
    assign o_flush        = r_flush;
    assign o_fetch_count  = r_fetch_count;

`ifdef PC_MISALIGN_TRAP_EN
    assign o_misaligned      = r_misaligned;
    assign o_misaligned_addr = r_misaligned_addr;
`else
    assign o_misaligned      = 1'b0;
    assign o_misaligned_addr = '0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: scoreboard bench for pc_unit (default parameters: XLEN 32, IALIGN 32).
// The driver applies directed and random stimulus and pushes the reference model's
// expected outputs for each edge. The monitor pops one entry per cycle and compares it.
module tb_pc_unit;

    localparam logic [31:0] RV      = 32'h0000_0000;
    localparam logic [31:0] TV      = 32'h0000_0100;
    localparam int unsigned STEP_B  = 4;

    logic        clk;
    logic        rst;
    logic        pc_en;
    logic        rv;
    logic [31:0] rpc;
    logic        tv;
    logic [31:0] pc;
    logic [31:0] pps;
    logic        fv;
    logic        fl;
    logic        mis;
    logic [31:0] mis_addr;
    logic [31:0] cnt;

    pc_unit dut (
        .i_clock           (clk),
        .i_reset           (rst),
        .i_pc_en           (pc_en),
        .i_redirect_valid  (rv),
        .i_redirect_pc     (rpc),
        .i_trap_valid      (tv),
        .o_pc              (pc),
        .o_pc_plus_step    (pps),
        .o_fetch_valid     (fv),
        .o_flush           (fl),
        .o_misaligned      (mis),
        .o_misaligned_addr (mis_addr),
        .o_fetch_count     (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pps;
        logic        fv;
        logic        fl;
        logic        mis;
        logic [31:0] addr;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   txn    = 0;

    // Reference model state: whether the unit is booting or halted, plus the architectural values.
    bit          m_boot = 1'b1;
    bit          m_halt = 1'b0;
    logic [31:0] m_pc   = RV;
    logic [31:0] m_cnt  = '0;
    bit          m_fl   = 1'b0;
    bit          m_mis  = 1'b0;
    logic [31:0] m_addr = '0;

    task automatic model_step(input bit r, input bit en, input bit rdv,
                              input logic [31:0] rdpc, input bit trp);
        m_fl  = 1'b0;
        m_mis = 1'b0;
        if (r) begin
            m_boot = 1'b1; m_halt = 1'b0; m_pc = RV; m_cnt = '0; m_addr = '0;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_halt) begin
            if (trp) begin
                m_pc = TV; m_fl = 1'b1; m_halt = 1'b0;
            end
        end else if (trp) begin
            m_pc = TV; m_fl = 1'b1; m_cnt = m_cnt + 1;
        end else if (rdv) begin
            if (rdpc % STEP_B == 0) begin
                m_pc = rdpc; m_fl = 1'b1; m_cnt = m_cnt + 1;
            end else begin
`ifdef PC_MISALIGN_TRAP_EN
                m_mis = 1'b1; m_addr = rdpc; m_halt = 1'b1;
`else
                m_pc = rdpc - (rdpc % STEP_B); m_fl = 1'b1; m_cnt = m_cnt + 1;
`endif
            end
        end else if (en) begin
            m_pc = m_pc + STEP_B; m_cnt = m_cnt + 1;
        end
    endtask

    // One cycle: drive at the negedge, let the posedge consume it, then record the expected outputs.
    task automatic cycle(input bit r, input bit en, input bit rdv,
                         input logic [31:0] rdpc, input bit trp);
        exp_t e;
        @(negedge clk);
        rst = r; pc_en = en; rv = rdv; rpc = rdpc; tv = trp;
        @(posedge clk);
        #1;
        model_step(r, en, rdv, rdpc, trp);
        e.pc   = m_pc;
        e.pps  = m_pc + STEP_B;
        e.fv   = !m_boot && !m_halt;
        e.fl   = m_fl;
        e.mis  = m_mis;
        e.addr = m_addr;
        e.cnt  = m_cnt;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s txn=%0d: got %h expected %h", name, txn, act, exp_v);
        end
    endtask

    // Monitor: one output set per cycle, compared against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (q.size() > 0) begin
                e = q.pop_front();
                txn++;
                $display("txn %0d: pc=%h fv=%b flush=%b mis=%b cnt=%0d", txn, pc, fv, fl, mis, cnt);
                chk("pc", pc, e.pc);
                chk("pc_plus_step", pps, e.pps);
                chk("fetch_valid", {31'b0, fv}, {31'b0, e.fv});
                chk("flush", {31'b0, fl}, {31'b0, e.fl});
                chk("misaligned", {31'b0, mis}, {31'b0, e.mis});
                chk("misaligned_addr", mis_addr, e.addr);
                chk("fetch_count", cnt, e.cnt);
            end
        end
    end

    // Driver: the directed test-plan sequences first, then random traffic.
    initial begin
        logic [31:0] tgt;
        bit          r_b, en_b, rv_b, tv_b;
        rst = 1'b1; pc_en = 1'b0; rv = 1'b0; rpc = '0; tv = 1'b0;
        // Reset and boot, then sequential fetches.
        cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);                 // BOOT -> RUN, pc still 0
        cycle(0, 1, 0, 0, 0);                 // 0x4
        cycle(0, 1, 0, 0, 0);                 // 0x8
        // Stall at 0x8 for three cycles, then advance.
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);                 // 0xC, count 3
        // Redirect under stall.
        cycle(0, 0, 1, 32'h0000_0200, 0);
        cycle(0, 0, 0, 0, 0);
        // Simultaneous trap and redirect: the trap wins.
        cycle(0, 1, 1, 32'h0000_0400, 1);
        cycle(0, 1, 0, 0, 0);
        // Reset in the same cycle as a trap.
        cycle(1, 1, 1, 32'h0000_0400, 1);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        // Misaligned redirect, then a trap out.
        cycle(0, 1, 1, 32'h0000_0302, 0);
        cycle(0, 1, 1, 32'h0000_0500, 0);
        cycle(0, 1, 0, 0, 1);
        cycle(0, 1, 0, 0, 0);
        // Wrap at the top of the address space.
        cycle(0, 0, 1, 32'hFFFF_FFFC, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            r_b  = ($urandom_range(0, 49) == 0);
            en_b = ($urandom_range(0, 3) != 0);
            rv_b = ($urandom_range(0, 5) == 0);
            tv_b = ($urandom_range(0, 15) == 0);
            tgt  = $urandom;
            if ($urandom_range(0, 3) != 0) tgt = tgt & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF8;
            cycle(r_b, en_b, rv_b, tgt, tv_b);
        end
        cycle(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #5;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised fetch program-counter unit. Successor to the single-register PC with enable.
- Adds:
  - internal sequential increment
  - branch/jump redirect from EX
  - trap redirect
  - boot state
  - pipeline flush pulse
  - misaligned-target detection
  - fetch counter
- Sits at the head of the IF stage; drives the instruction-memory address and the IF/ID valid bit.

Parameters:
- XLEN, 32, PC and address width.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap_valid. Low alignment bits are forced to zero.
- IALIGN, 32, instruction alignment in bits. Legal values 32 or 16; step = IALIGN/8 bytes.
- CNT_W, 32, width of fetch_count.

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, synchronous, active-high.
- pc_en, input, 1, advance enable; 0 = stall, hold pc.
- redirect_valid, input, 1, taken branch/jump from EX.
- redirect_pc, input, XLEN, redirect target.
- trap_valid, input, 1, trap request.
- pc, output, XLEN, current fetch address (registered).
- pc_plus_step, output, XLEN, pc + IALIGN/8 (combinational).
- fetch_valid, output, 1, pc is a real fetch this cycle.
- flush, output, 1, one-cycle pulse: younger IF/ID contents invalid.
- misaligned, output, 1, one-cycle pulse: rejected misaligned redirect.
- misaligned_addr, output, XLEN, offending target (registered).
- fetch_count, output, CNT_W, count of accepted fetches.

Behaviour:
- States:
  - BOOT, RUN: always present.
  - HALT: present only with the optional feature.
- Reset (any state, any cycle, including mid-redirect): on the next edge
  - state=BOOT, pc=RESET_VECTOR, fetch_valid=0, flush=0
  - misaligned=0, misaligned_addr=0, fetch_count=0
- BOOT:
  - Lasts exactly one cycle after reset deasserts; fetch_valid=0, pc holds RESET_VECTOR.
  - Next edge goes to RUN; pc is unchanged, so the first fetch is RESET_VECTOR.
- RUN, evaluated each edge in priority order:
  1. trap_valid: pc<=TRAP_VECTOR, flush<=1.
  2. redirect_valid with an aligned target: pc<=redirect_pc, flush<=1.
  3. pc_en: pc<=pc+IALIGN/8.
  4. else: hold.
- Trap and redirect are not gated by pc_en; redirect overrides stall. Simultaneous trap and redirect: trap wins, redirect dropped.
- flush is registered: high for exactly the one cycle in which pc first shows the new target; low otherwise.
- fetch_valid=1 in RUN, 0 in BOOT and HALT.
- fetch_count increments on each edge where fetch_valid=1 and the PC moves (pc_en=1, or redirect/trap accepted). Wraps modulo 2^CNT_W silently.
- Arithmetic: pc+step is modulo 2^XLEN; 0xFFFF_FFFC+4=0x0000_0000 with no flag.
- Alignment: a target is aligned when its bits [log2(IALIGN/8)-1:0] are zero, i.e. [1:0] for 32 and [0] for 16.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned redirect in RUN: pc held; misaligned pulses 1 for one cycle; misaligned_addr<=redirect_pc; state->HALT; fetch_count unchanged.
  - HALT: fetch_valid=0, pc held; redirect_valid and pc_en ignored.
  - trap_valid in HALT: pc<=TRAP_VECTOR, flush<=1, state->RUN.
- Undefined:
  - Misaligned redirect is accepted with alignment bits cleared (redirect_pc & ~(IALIGN/8-1)); flush<=1.
  - misaligned and misaligned_addr are tied to 0; HALT state does not exist.

Test Plan:
- Reset/boot: reset=1 for 2 cycles, release with pc_en=1 → pc=0x0 for BOOT cycle (fetch_valid=0) plus one RUN cycle, then 0x4, 0x8, 0xC; fetch_count=3 after 0xC shown.
- Stall: pc_en=0 for 3 cycles at pc=0x8 → pc stays 0x8, fetch_count frozen; pc_en=1 → 0xC.
- Redirect under stall: pc_en=0, redirect_valid=1, redirect_pc=0x200 for one cycle → next cycle pc=0x200, flush=1; following cycle flush=0, pc=0x200 (still stalled).
- Simultaneous events: trap_valid=1 and redirect_valid=1 (0x400) in same cycle → pc=0x100, flush=1; redirect lost. Mid-operation reset during trap → pc=0x0, BOOT, flush=0.
- Misaligned redirect_pc=0x302:
  - With macro: misaligned=1 one cycle, misaligned_addr=0x302, fetch_valid=0, pc held; trap_valid → pc=0x100, RUN.
  - Without macro: pc=0x300, flush=1, misaligned=0.
- Wrap: redirect to 0xFFFF_FFFC, pc_en=1 → next pc=0x0000_0000. IALIGN=16 build: step 2; redirect 0x102 accepted; 0x101 misaligned.
